// File: rtl/cf_axis_sched.sv
// cf_axis_sched: buffers per-axis IMU samples and, once per tick, issues every
// pending axis in X,Y,Z order to a shared filter datapath, storing each returned angle.
module cf_axis_sched #(
    parameter int TICK_DIV = 5000,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        en,
    input  logic        wr_valid,
    input  logic [1:0]  wr_axis,
    input  logic [15:0] wr_gyro,
    input  logic [15:0] wr_a,
    input  logic [15:0] wr_b,
    output logic        dp_start,
    output logic [1:0]  dp_axis,
    output logic [15:0] dp_gyro,
    output logic [15:0] dp_a,
    output logic [15:0] dp_b,
    input  logic        dp_done,
    input  logic [31:0] dp_angle,
    output logic [31:0] angle_x,
    output logic [31:0] angle_y,
    output logic [31:0] angle_z,
    output logic [2:0]  upd,
    output logic [3:0]  status,
    input  logic        clr_status,
    output logic [1:0]  dbg_state_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        STORE = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TMR_W-1:0] tmr_q;
    logic [2:0]       pending_q, pending_d;
    logic [2:0]       mask_q;
    logic [2:0][47:0] buf_q;
    logic [2:0][47:0] work_q;
    logic [2:0][31:0] angle_q;
    logic [3:0]       status_q, status_d;
    logic             dp_start_q;
    logic [1:0]       dp_axis_q;
    logic [47:0]      dp_ops_q;
    logic [2:0]       upd_q;

    logic             tick, snap, wr_ok, to_hit;
    logic [1:0]       pick;
    logic [2:0]       rest;

    // Datapath handshake: dp_start is a one-cycle request with operands held
    // until the next issue; dp_done is a one-cycle reply honoured only in WAIT.
    always_comb begin
        tick      = en && (cnt_q == CNT_W'(TICK_DIV - 1));
        snap      = tick && (state_q == IDLE);
        wr_ok     = wr_valid && (wr_axis != 2'd3);
        to_hit    = (state_q == WAIT) && !dp_done && (tmr_q == TMR_W'(TIMEOUT - 1));
        pick      = mask_q[0] ? 2'd0 : (mask_q[1] ? 2'd1 : 2'd2);
        rest      = mask_q & ~(3'b001 << dp_axis_q);
        pending_d = snap ? 3'b000 : pending_q;
        if (wr_ok) begin
            pending_d[wr_axis] = 1'b1;
        end
        status_d = clr_status ? 4'b0000 : status_q;
        status_d = status_d | {to_hit,
                               wr_valid && (wr_axis == 2'd3),
                               tick && (state_q != IDLE),
                               wr_ok && pending_q[wr_axis] && !snap};
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tmr_q      <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            buf_q      <= '0;
            work_q     <= '0;
            angle_q    <= '0;
            status_q   <= '0;
            dp_start_q <= 1'b0;
            dp_axis_q  <= '0;
            dp_ops_q   <= '0;
            upd_q      <= '0;
        end else begin
            cnt_q      <= (!en || tick) ? '0 : cnt_q + 1'b1;
            pending_q  <= pending_d;
            status_q   <= status_d;
            dp_start_q <= 1'b0;
            upd_q      <= '0;
            if (wr_ok) begin
                buf_q[wr_axis] <= {wr_gyro, wr_a, wr_b};
            end
            case (state_q)
                IDLE: begin
                    // The round works from a copy, so same-cycle writes wait for the next tick.
                    if (snap) begin
                        mask_q <= pending_q;
                        work_q <= buf_q;
                        if (pending_q != 3'b000) begin
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    dp_axis_q  <= pick;
                    dp_ops_q   <= work_q[pick];
                    dp_start_q <= 1'b1;
                    tmr_q      <= '0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (dp_done) begin
                        angle_q[dp_axis_q] <= dp_angle;
                        upd_q[dp_axis_q]   <= 1'b1;
                        state_q            <= STORE;
                    end else if (to_hit) begin
                        mask_q  <= rest;
                        state_q <= (rest != 3'b000) ? ISSUE : IDLE;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                STORE: begin
                    mask_q  <= rest;
                    state_q <= (rest != 3'b000) ? ISSUE : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dp_start    = dp_start_q;
    assign dp_axis     = dp_axis_q;
    assign dp_gyro     = dp_ops_q[47:32];
    assign dp_a        = dp_ops_q[31:16];
    assign dp_b        = dp_ops_q[15:0];
    assign angle_x     = angle_q[0];
    assign angle_y     = angle_q[1];
    assign angle_z     = angle_q[2];
    assign upd         = upd_q;
    assign status      = status_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cf_axis_sched.sv
// Bench for cf_axis_sched: directed scenarios plus randomized traffic, checked every
// cycle against a timeline model built from the scheduler's latency and ordering rules.
module tb_cf_axis_sched;

  localparam int TD  = 8;
  localparam int TO  = 16;
  localparam int BIG = 1 << 30;

  // clock / reset
  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic        en = 1'b0;
  logic        wr_valid = 1'b0;
  logic [1:0]  wr_axis = '0;
  logic [15:0] wr_gyro = '0, wr_a = '0, wr_b = '0;
  logic        dp_start;
  logic [1:0]  dp_axis;
  logic [15:0] dp_gyro, dp_a, dp_b;
  logic        dp_done = 1'b0;
  logic [31:0] dp_angle = '0;
  logic [31:0] angle_x, angle_y, angle_z;
  logic [2:0]  upd;
  logic [3:0]  status;
  logic        clr_status = 1'b0;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  cf_axis_sched #(.TICK_DIV(TD), .TIMEOUT(TO)) dut (
    .clk(clk), .RST(RST), .en(en),
    .wr_valid(wr_valid), .wr_axis(wr_axis), .wr_gyro(wr_gyro), .wr_a(wr_a), .wr_b(wr_b),
    .dp_start(dp_start), .dp_axis(dp_axis), .dp_gyro(dp_gyro), .dp_a(dp_a), .dp_b(dp_b),
    .dp_done(dp_done), .dp_angle(dp_angle),
    .angle_x(angle_x), .angle_y(angle_y), .angle_z(angle_z),
    .upd(upd), .status(status), .clr_status(clr_status), .dbg_state_o(dbg_state)
  );

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: abstract issue queue plus expected event times (step indices)
  int          k = 0;
  logic [2:0]  m_pend;
  logic [47:0] m_buf[3];
  logic [31:0] m_ang[3];
  logic [3:0]  m_st;
  logic [49:0] exp_q[$];
  logic [49:0] m_last;
  int          next_start, idle_from, done_step, to_step, upd_at, m_cnt;
  logic [2:0]  upd_val;
  bit          in_wait;
  logic [1:0]  cur_axis;
  logic [31:0] done_angle;
  int          force_q[$];
  logic [31:0] fangle_q[$];

  // driver controls
  bit          d_wr = 0, d_en = 0, d_clr = 0, d_spur = 0;
  logic [1:0]  d_axis = '0;
  logic [47:0] d_data = '0;

  task automatic model_reset();
    m_pend = '0;
    for (int i = 0; i < 3; i++) begin
      m_buf[i] = '0;
      m_ang[i] = '0;
    end
    m_st = '0;
    exp_q.delete();
    force_q.delete();
    fangle_q.delete();
    m_last = '0;
    next_start = -1;
    idle_from = 0;
    done_step = -1;
    to_step = -1;
    upd_at = -1;
    upd_val = '0;
    in_wait = 0;
    m_cnt = 0;
    cur_axis = '0;
    done_angle = '0;
  endtask

  task automatic resolve(input int at);
    if (exp_q.size() > 0) next_start = at;
    else idle_from = at;
  endtask

  // one clock: drive inputs, advance the model across the edge, check outputs at negedge
  task automatic step();
    bit tick, ovr, ill, miss, tmo, done_now;
    int f;
    wr_valid = d_wr;
    wr_axis = d_axis;
    {wr_gyro, wr_a, wr_b} = d_data;
    en = d_en;
    clr_status = d_clr;
    done_now = in_wait && (k == done_step);
    dp_done = done_now || (d_spur && !in_wait);
    dp_angle = done_now ? done_angle : $urandom();

    tick = 0;
    miss = 0;
    ovr = 0;
    ill = 0;
    tmo = 0;
    if (!d_en) m_cnt = 0;
    else if (m_cnt == TD - 1) begin
      tick = 1;
      m_cnt = 0;
    end else m_cnt++;
    if (tick) begin
      if (k >= idle_from) begin
        for (int i = 0; i < 3; i++)
          if (m_pend[i]) exp_q.push_back({2'(i), m_buf[i]});
        m_pend = '0;
        if (exp_q.size() > 0) begin
          next_start = k + 1;
          idle_from = BIG;
        end
      end else miss = 1;
    end
    if (d_wr) begin
      if (d_axis == 2'd3) ill = 1;
      else begin
        ovr = m_pend[d_axis];
        m_pend[d_axis] = 1'b1;
        m_buf[d_axis] = d_data;
      end
    end
    if (done_now) begin
      m_ang[cur_axis] = done_angle;
      upd_at = k;
      upd_val = 3'b001 << cur_axis;
      in_wait = 0;
      resolve(k + 2);
    end else if (in_wait && k == to_step) begin
      tmo = 1;
      in_wait = 0;
      resolve(k + 1);
    end
    if (d_clr) m_st = '0;
    m_st = m_st | {tmo, ill, miss, ovr};

    @(negedge clk);
    check("dp_start", dp_start, (k == next_start) ? 1 : 0);
    if (k == next_start && exp_q.size() > 0) begin
      m_last = exp_q.pop_front();
      cur_axis = m_last[49:48];
      in_wait = 1;
      next_start = -1;
      if (force_q.size() > 0) f = force_q.pop_front();
      else f = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      done_angle = (fangle_q.size() > 0) ? fangle_q.pop_front() : $urandom();
      if (f < 0) begin
        to_step = k + TO;
        done_step = -1;
      end else begin
        done_step = k + 1 + f;
        to_step = -1;
      end
    end
    check("dp_axis", dp_axis, m_last[49:48]);
    check("dp_gyro", dp_gyro, m_last[47:32]);
    check("dp_a", dp_a, m_last[31:16]);
    check("dp_b", dp_b, m_last[15:0]);
    check("upd", upd, (k == upd_at) ? upd_val : 3'b000);
    check("angle_x", angle_x, m_ang[0]);
    check("angle_y", angle_y, m_ang[1]);
    check("angle_z", angle_z, m_ang[2]);
    check("status", status, m_st);
    k++;
  endtask

  task automatic quiet();
    d_wr = 0;
    d_en = 0;
    d_clr = 0;
    d_spur = 0;
  endtask

  task automatic wr(input logic [1:0] axis, input logic [47:0] data);
    d_wr = 1;
    d_axis = axis;
    d_data = data;
    step();
    d_wr = 0;
  endtask

  task automatic tick_burst();
    d_en = 1;
    repeat (TD) step();
    d_en = 0;
  endtask

  task automatic drain();
    int n;
    quiet();
    n = 0;
    while (!(next_start < 0 && !in_wait && k >= idle_from && exp_q.size() == 0) && n < 400) begin
      step();
      n++;
    end
    check("drain_bound", (n < 400) ? 1 : 0, 1);
    step();
  endtask

  task automatic do_reset();
    RST = 1'b0;
    wr_valid = 1'b0;
    en = 1'b0;
    dp_done = 1'b0;
    clr_status = 1'b0;
    #1;
    check("rst_dp_start", dp_start, 0);
    check("rst_dp_axis", dp_axis, 0);
    check("rst_ops", {dp_gyro, dp_a}, 0);
    check("rst_dp_b", dp_b, 0);
    check("rst_angle_x", angle_x, 0);
    check("rst_angle_y", angle_y, 0);
    check("rst_angle_z", angle_z, 0);
    check("rst_upd", upd, 0);
    check("rst_status", status, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    RST = 1'b1;
    model_reset();
    k++;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    quiet();
    step();

    // single Y sample, fixed operands and result
    wr(2'd1, {16'h0040, 16'h2000, 16'h1000});
    force_q.push_back(0);
    fangle_q.push_back(32'h12345678);
    tick_burst();
    drain();
    check("dir_angle_y", angle_y, 32'h12345678);

    // three axes written Z, X, Y
    wr(2'd2, {16'h3333, 16'h3334, 16'h3335});
    wr(2'd0, {16'h1111, 16'h1112, 16'h1113});
    wr(2'd1, {16'h2222, 16'h2223, 16'h2224});
    tick_burst();
    drain();

    // overrun on X, illegal axis 3
    wr(2'd0, {16'hA000, 16'hA001, 16'hA002});
    wr(2'd0, {16'hB000, 16'hB001, 16'hB002});
    wr(2'd3, {16'hC000, 16'hC001, 16'hC002});
    check("dir_overrun", status[0], 1);
    check("dir_illegal", status[2], 1);
    tick_burst();
    drain();
    d_clr = 1;
    step();
    d_clr = 0;

    // timeout on X, then Y served
    wr(2'd0, {16'h0101, 16'h0202, 16'h0303});
    wr(2'd1, {16'h0404, 16'h0505, 16'h0606});
    force_q.push_back(-1);
    force_q.push_back(1);
    tick_burst();
    drain();
    check("dir_timeout", status[3], 1);
    d_clr = 1;
    step();
    d_clr = 0;

    // tick arriving while a slow datapath is still busy
    wr(2'd0, {16'h0777, 16'h0888, 16'h0999});
    force_q.push_back(10);
    d_en = 1;
    repeat (2 * TD) step();
    d_en = 0;
    drain();
    check("dir_tick_miss", status[1], 1);
    d_clr = 1;
    step();
    d_clr = 0;
    check("dir_clr", status, 0);

    // reset while waiting, then a stale dp_done
    wr(2'd2, {16'h0DEF, 16'h0ABC, 16'h0123});
    force_q.push_back(-1);
    tick_burst();
    repeat (3) step();
    do_reset();
    d_spur = 1;
    step();
    d_spur = 0;
    check("dir_late_done", upd, 0);
    step();

    // randomized traffic
    begin
      int en_left;
      en_left = 0;
      for (int n = 0; n < 2500; n++) begin
        d_wr = ($urandom_range(0, 3) == 0);
        d_axis = 2'($urandom_range(0, 3));
        d_data = {16'($urandom), 16'($urandom), 16'($urandom)};
        if (en_left == 0 && $urandom_range(0, 11) == 0) en_left = TD * int'($urandom_range(1, 2));
        d_en = (en_left > 0);
        if (en_left > 0) en_left--;
        d_clr = ($urandom_range(0, 40) == 0);
        d_spur = ($urandom_range(0, 7) == 0);
        step();
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/cf_axis_sched.md
CF_AXIS_SCHED -- requirements
Module: cf_axis_sched

Interface
REQ-001 SHALL have parameter TICK_DIV, default 5000, clk cycles per filter update period (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum cycles to wait for dp_done.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  scheduler enable; tick counter runs only when high.
REQ-006 SHALL have port wr_valid  input  1  sample-write strobe from sensor reader.
REQ-007 SHALL have port wr_axis  input  2  target axis: 0=X, 1=Y, 2=Z; 3 is illegal.
REQ-008 SHALL have port wr_gyro, wr_a, wr_b  input  16 each  gyro rate and two accel components for that axis.
REQ-009 SHALL have port dp_start  output  1  one-cycle start pulse to the shared filter datapath.
REQ-010 SHALL have port dp_axis  output  2  axis currently issued.
REQ-011 SHALL have port dp_gyro, dp_a, dp_b  output  16 each  operands held stable from dp_start until dp_done or timeout.
REQ-012 SHALL have port dp_done  input  1  datapath completion, one cycle.
REQ-013 SHALL have port dp_angle  input  32  datapath result, valid with dp_done.
REQ-014 SHALL have port angle_x, angle_y, angle_z  output  32 each  latest result per axis.
REQ-015 SHALL have port upd  output  3  one-cycle strobe, bit n set the cycle angle_n updates.
REQ-016 SHALL have port status  output  4  sticky flags {timeout, illegal_axis, tick_miss, overrun}, bit 3..0.
REQ-017 SHALL have port clr_status  input  1  clears status flags.

Function
REQ-018 SHALL keep per-axis buffers {gyro,a,b} and pending[2:0]; wr_valid with axis n<3 loads buffer n and sets pending[n].
REQ-019 SHALL, on wr_valid to an axis already pending, overwrite the buffer and set overrun.
REQ-020 SHALL ignore wr_valid with wr_axis=3 (no buffer change) and set illegal_axis.
REQ-021 SHALL generate tick when the tick counter reaches TICK_DIV-1, then wrap it to 0; counter held at 0 while en=0.
REQ-022 SHALL use states IDLE, ISSUE, WAIT, STORE.
REQ-023 SHALL, in IDLE on tick, snapshot pending into a work mask and clear those pending bits in the same cycle; go to ISSUE if the mask is nonzero, else stay IDLE.
REQ-024 SHALL give a wr_valid that coincides with the snapshot cycle priority: that axis stays pending for the next tick, and its data is not used in the current round.
REQ-025 SHALL, in ISSUE, pick the lowest-numbered set mask bit (X before Y before Z), drive dp_axis/operands from that buffer copy, pulse dp_start, clear timer, go to WAIT.
REQ-026 SHALL latch operands at ISSUE; buffer writes during WAIT do not alter dp_gyro/dp_a/dp_b.
REQ-027 SHALL, in WAIT, on dp_done go to STORE; if the timer reaches TIMEOUT with no dp_done, set timeout, clear that mask bit, leave angle unchanged, return to ISSUE if bits remain, else IDLE.
REQ-028 SHALL, in STORE, write the dp_angle captured at dp_done to angle_<dp_axis>, pulse upd bit, clear mask bit, go to ISSUE if bits remain, else IDLE.
REQ-029 SHALL ignore dp_done outside WAIT.
REQ-030 SHALL set tick_miss on a tick outside IDLE, without queuing that tick.
REQ-031 SHALL have latency from dp_done to upd of exactly 1 cycle and from tick to first dp_start of exactly 2 cycles.
REQ-032 SHALL clear status flags on clr_status; a set event in the same cycle wins.
REQ-033 SHALL, on en falling mid-round, finish the current round; no new ticks are generated.

Reset
REQ-034 SHALL, on RST low, asynchronously force state IDLE, counter 0, pending/mask 0, buffers 0, dp_start 0, dp_axis 0, operands 0, angles 0, upd 0, status 0.
REQ-035 SHALL abandon an in-flight operation on reset mid-round; a dp_done after reset is ignored.

Verification
REQ-036 Single axis: write Y {gyro=0x0040,a=0x2000,b=0x1000}, tick -> 2 cycles later dp_start with dp_axis=1 and those operands; dp_done with dp_angle=0x12345678 -> next cycle angle_y=0x12345678, upd=3'b010.
REQ-037 Three axes: write Z, X, Y, tick -> issue order X, Y, Z; three upd pulses 3'b001, 3'b010, 3'b100.
REQ-038 Overrun/illegal: two writes to X before tick -> status[0]=1, second data issued; write axis 3 -> status[2]=1, no pending change.
REQ-039 Timeout: withhold dp_done for TIMEOUT cycles -> status[3]=1, angle unchanged, next axis issued.
REQ-040 Tick miss: TICK_DIV=8, dp_done delayed 10 cycles -> status[1]=1; clr_status -> status=0.
REQ-041 Reset mid-WAIT: assert RST -> all outputs 0 immediately; late dp_done -> no upd.
